bus_terminal_fifo: RTL
======================

// Module: bus_terminal_fifo
// PURPOSE
// Per-terminal transmit FIFO that sits directly upstream of the bus generator/arbiter (bs_gnrtr_n_rbtr).
// A terminal device pushes packets in; the FIFO presents the head packet to the arbiter via pndng/D_pop.
// The arbiter consumes the head with pop. One instance per driver per bus; the bench replaces its FIFO emulation with it.
// Also tracks occupancy, sticky overflow and a count of dropped packets for scoreboard cross-checking.
// PARAMETERS
// pckg_sz    16   packet width in bits; bits [pckg_sz-1 -: 8] hold destination ID (8'hFF = broadcast)
// depth      8    FIFO entries; must be a power of two, >= 2
// cnt_w      8    width of drop counter; counter saturates at all-ones
// PORTS
// clk        in   1              bus clock; all state on rising edge
// reset      in   1              asynchronous, active-low reset (0 = reset asserted)
// push       in   1              device write strobe; writes data_in this cycle
// data_in    in   pckg_sz        packet from device
// full       out  1              depth entries held
// pndng      out  1              FIFO non-empty; to arbiter pndng[bit][drvr]
// D_pop      out  pckg_sz        head packet (show-ahead); to arbiter D_pop[bit][drvr]
// pop        in   1              arbiter read strobe; from arbiter pop[bit][drvr]
// count      out  $clog2(depth)+1 current occupancy, 0..depth
// overflow   out  1              sticky: set on any dropped push; cleared only by reset
// drop_cnt   out  cnt_w          number of dropped pushes, saturating
// BEHAVIOUR
// - Reset (reset==0, async): wr_ptr=rd_ptr=0, count=0, full=0, pndng=0, overflow=0, drop_cnt=0.
//   D_pop is driven to 0 while count==0, including during reset. Memory contents are not cleared.
// - Reset deassertion is synchronised by the instantiating level.
//   The block samples reset asynchronously on assertion only.
// - Storage: circular buffer with wr_ptr and rd_ptr of $clog2(depth) bits; natural wrap from depth-1 to 0.
// - Flags and D_pop are derived from registered state only (no combinational path from push/pop).
//   pndng = (count!=0); full = (count==depth).
// - Latency: a push at edge N makes pndng=1 and D_pop=data_in valid after edge N (visible in cycle N+1).
//   No fall-through in the push cycle.
// - Pop: accepted at an edge when pop && pndng. rd_ptr++ and count--; the next entry appears on D_pop after that edge.
// - Pop while pndng==0: ignored, no state change. An arbiter must never do this; the bench flags it as an arbiter error.
// - Push while !full: mem[wr_ptr]<=data_in, wr_ptr++, count++.
// - Push while full and no accepted pop: packet dropped, FIFO unchanged, overflow<=1, drop_cnt++ (saturating).
// - Simultaneous push and accepted pop: both performed, count unchanged. This holds when full (no drop) and any non-empty count.
//   When count==0, the pop is not accepted and the push proceeds normally.
// - drop_cnt saturates at {cnt_w{1'b1}}; further drops leave it there and overflow stays 1.
// - Reset mid-operation: all queued packets are discarded; pndng falls asynchronously with reset.
// - No packet content checks: destination/broadcast fields pass through unmodified.
// STRUCTURE
// - Shared package bus_pkg: localparam BROADCAST_ID=8'hFF, typedef logic [pckg_sz-1:0] pkt_t (parameterised via class/param).
//   Also a function dest_id(pkt) returning the top 8 bits, for use by bench and arbiter checkers.
// - One natural sub-module: bus_fifo_mem (depth x pckg_sz register array, one write port, one async read port at rd_ptr).
//   Pointers, count, flags and counters stay in bus_terminal_fifo.
// - The bench instantiates drvrs*bits copies and connects them to bus_intf.pndng/pop/D_pop.
// TESTING
// 1 Reset: hold reset=0 for 5 cycles while toggling push
//   -> pndng=0, full=0, count=0, D_pop=0, overflow=0, drop_cnt=0 throughout.
// 2 Ordering: push 16'h0A01,16'h0B02,16'h0C03 on consecutive cycles, then pop 3x
//   -> D_pop shows 0A01,0B02,0C03 in order; count 3->0; pndng=0 after the last pop.
// 3 Overflow (depth=8): push 10 packets, no pops
//   -> full=1 after the 8th; packets 9 and 10 are dropped; overflow=1, drop_cnt=2; pops return packets 1..8 only.
// 4 Full with simultaneous push+pop: fill to 8, then push 16'hFF55 with pop in the same cycle
//   -> count stays 8, no drop, drop_cnt unchanged, 16'hFF55 is the last entry popped.
// 5 Wrap-around: 20 push/pop pairs interleaved with 0..3 entries in flight
//   -> output sequence equals input sequence, pointers wrap cleanly, count never exceeds 4.
// 6 Reset mid-stream: 5 entries queued, assert reset for 1 cycle, release, push 16'h1234
//   -> count=1, D_pop=16'h1234, overflow=0.
// Plus: pop with pndng=0 -> no state change; 300 drops with cnt_w=8 -> drop_cnt=255.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: packet type, broadcast ID and destination-field helper.
package bus_pkg;

    localparam int unsigned PKT_W        = 16;
    localparam logic [7:0]  BROADCAST_ID = 8'hFF;

    typedef logic [PKT_W-1:0] pkt_t;

    function automatic logic [7:0] dest_id(input pkt_t pkt);
        return pkt[PKT_W-1 -: 8];
    endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module bus_fifo_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are intentionally not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_terminal_fifo.sv
// Per-terminal transmit FIFO feeding the bus arbiter; show-ahead head with
// occupancy, sticky overflow and a saturating drop counter.
module bus_terminal_fifo
    import bus_pkg::*;
#(
    parameter int unsigned pckg_sz = PKT_W,
    parameter int unsigned depth   = 8,
    parameter int unsigned cnt_w   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       data_in,
    output logic                     full,
    output logic                     pndng,
    output logic [pckg_sz-1:0]       D_pop,
    input  logic                     pop,
    output logic [$clog2(depth):0]   count,
    output logic                     overflow,
    output logic [cnt_w-1:0]         drop_cnt
);

    localparam int unsigned PTR_W = $clog2(depth);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               pndng_q, pndng_d;
    logic               overflow_q, overflow_d;
    logic [cnt_w-1:0]   drop_cnt_q, drop_cnt_d;
    logic               pop_ok, push_ok, drop;
    logic [pckg_sz-1:0] head;

    bus_fifo_mem #(
        .WIDTH (pckg_sz),
        .DEPTH (depth)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    // A pop frees a slot in the same edge, so a push against a full FIFO with an accepted pop is not a drop.
    always_comb begin
        pop_ok      = pop && pndng_q;
        push_ok     = push && (!full_q || pop_ok);
        drop        = push && full_q && !pop_ok;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {cnt_w{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + cnt_w'(1);
            end
        end

        full_d  = (count_d == OCC_W'(depth));
        pndng_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            pndng_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            pndng_q    <= pndng_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign full     = full_q;
    assign pndng    = pndng_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign D_pop    = pndng_q ? head : '0;

endmodule
